pipe_stage_chain: RTL and testbench

- Parametrised pipeline-register chain: NUM_STAGES stages of DATA_WIDTH payload, each with a valid bit.
- Generalises the fixed fetch/decode/execute/memory stage registers into one block, with a valid/ready handshake at both ends.
- Per-stage stall and flush inputs come from the hazard unit.
- Per-stage state is exported for forwarding and debug.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_stage_chain_if.sv | 23 ++
 rtl/pipe_stage_reg.sv | 48 ++++
 rtl/pipe_stage_chain.sv | 104 ++++++++++
 tb/tb_pipe_stage_chain.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared defaults and the per-stage record layout for the pipeline-register chain.
package pipe_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_STAGES = 4;
  localparam int DEF_CNT_WIDTH  = 16;

  // Default-width stage record; modules with other widths declare the same layout locally.
  typedef struct packed {
    logic                      valid;
    logic [DEF_DATA_WIDTH-1:0] data;
  } stage_t;

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Upstream/downstream valid-ready handshake of the stage chain.
interface pipe_stage_chain_if #(
  parameter int DATA_WIDTH = pipe_pkg::DEF_DATA_WIDTH
);

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: flush beats hold; payload only loads alongside a valid item.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hold_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
  } stage_w_t;

  stage_w_t stage_q;
  stage_w_t stage_d;

  always_comb begin
    stage_d = stage_q;
    if (flush_i) begin
      stage_d.valid = 1'b0;
    end else if (!hold_i) begin
      stage_d.valid = valid_i;
      if (valid_i) begin
        stage_d.data = data_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign valid_o = stage_q.valid;
  assign data_o  = stage_q.data;

endmodule

// File: rtl/pipe_stage_chain.sv
// NUM_STAGES-deep register chain with valid/ready ends, per-stage stall/flush and drop counting.
// Define PIPE_BUBBLE_COLLAPSE_EN to let younger items advance into bubbles (empty stages never hold).
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  pipe_stage_chain_if.slave                bus,
  input  logic [NUM_STAGES-1:0]            stall_i,
  input  logic [NUM_STAGES-1:0]            flush_i,
  output logic [NUM_STAGES-1:0]            stage_valid_o,
  output logic [NUM_STAGES*DATA_WIDTH-1:0] stage_data_o,
  output logic [$clog2(NUM_STAGES+1)-1:0]  occupancy_o,
  output logic [CNT_WIDTH-1:0]             drop_cnt_o
);

  localparam int OCC_W = $clog2(NUM_STAGES+1);
  localparam int SUM_W = CNT_WIDTH + 1;

  logic [NUM_STAGES-1:0]                 stage_valid;
  logic [NUM_STAGES-1:0][DATA_WIDTH-1:0] stage_data;
  logic [NUM_STAGES-1:0]                 hold;
  logic [NUM_STAGES-1:0]                 stage_in_valid;
  logic [NUM_STAGES-1:0][DATA_WIDTH-1:0] stage_in_data;

  logic [OCC_W-1:0]     occ;
  logic [OCC_W-1:0]     drops;
  logic [SUM_W-1:0]     drop_sum;
  logic [CNT_WIDTH-1:0] drop_cnt_q;
  logic [CNT_WIDTH-1:0] drop_cnt_d;

  // Hold propagates from the oldest stage back toward the input.
  always_comb begin
    hold = '0;
`ifdef PIPE_BUBBLE_COLLAPSE_EN
    hold[NUM_STAGES-1] = stage_valid[NUM_STAGES-1] & (stall_i[NUM_STAGES-1] | ~bus.out_ready);
    for (int k = NUM_STAGES-2; k >= 0; k--) begin
      hold[k] = stage_valid[k] & (stall_i[k] | hold[k+1]);
    end
`else
    hold[NUM_STAGES-1] = stall_i[NUM_STAGES-1] | (stage_valid[NUM_STAGES-1] & ~bus.out_ready);
    for (int k = NUM_STAGES-2; k >= 0; k--) begin
      hold[k] = stall_i[k] | hold[k+1];
    end
`endif
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign stage_in_valid[k] = bus.in_valid;
      assign stage_in_data[k]  = bus.in_data;
    end else begin : g_body
      // A held predecessor hands this stage a bubble.
      assign stage_in_valid[k] = stage_valid[k-1] & ~hold[k-1];
      assign stage_in_data[k]  = stage_data[k-1];
    end

    pipe_stage_reg #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_stage (
      .clk    (clk),
      .rst_n  (reset),
      .hold_i (hold[k]),
      .flush_i(flush_i[k]),
      .valid_i(stage_in_valid[k]),
      .data_i (stage_in_data[k]),
      .valid_o(stage_valid[k]),
      .data_o (stage_data[k])
    );

    assign stage_data_o[k*DATA_WIDTH +: DATA_WIDTH] = stage_data[k];
  end

  always_comb begin
    occ   = '0;
    drops = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      occ   = occ + OCC_W'(stage_valid[k]);
      drops = drops + OCC_W'(flush_i[k] & stage_valid[k]);
    end
    drop_sum   = {1'b0, drop_cnt_q} + SUM_W'(drops);
    drop_cnt_d = drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.in_ready   = ~hold[0];
  assign bus.out_valid  = stage_valid[NUM_STAGES-1] & ~stall_i[NUM_STAGES-1];
  assign bus.out_data   = stage_data[NUM_STAGES-1];
  assign stage_valid_o  = stage_valid;
  assign occupancy_o    = occ;
  assign drop_cnt_o     = drop_cnt_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (4 stages x 32 bits) with hand-computed expectations.
module tb_pipe_stage_chain;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int CW = 16;
  localparam int OW = 3;
`ifdef PIPE_BUBBLE_COLLAPSE_EN
  localparam bit COLLAPSE = 1'b1;
`else
  localparam bit COLLAPSE = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  stall_i = '0;
  logic [N-1:0]  flush_i = '0;
  logic [N-1:0]  stage_valid_o;
  logic [N*DW-1:0] stage_data_o;
  logic [OW-1:0] occupancy_o;
  logic [CW-1:0] drop_cnt_o;

  int errors = 0;
  int checks = 0;

  pipe_stage_chain_if #(.DATA_WIDTH(DW)) bus ();

  pipe_stage_chain #(
    .DATA_WIDTH(DW),
    .NUM_STAGES(N),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .stage_valid_o(stage_valid_o),
    .stage_data_o (stage_data_o),
    .occupancy_o  (occupancy_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] sdata(input int k);
    return stage_data_o[k*DW +: DW];
  endfunction

  task automatic fill(input logic [DW-1:0] base);
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = base + DW'(i);
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // reset state
    #2;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_occ", occupancy_o, 3'd0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_drop", drop_cnt_o, 16'd0);
    chk("rst_stage_valid", stage_valid_o, 4'b0000);
    stall_i = 4'b0001;
    #1;
    chk("rst_in_ready_stall0", bus.in_ready, COLLAPSE ? 1'b1 : 1'b0);
    stall_i = '0;
    #5 reset = 1'b1;
    tick();

    // streaming: 4-edge latency
    for (int i = 0; i < N; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'h10 + i;
      bus.out_ready = 1'b1;
      #1;
      chk("lat_not_yet", bus.out_valid, 1'b0);
      tick();
    end

    // back-pressure on a full chain
    bus.out_ready = 1'b0;
    bus.in_data   = 32'h14;
    #1;
    chk("full_out_valid", bus.out_valid, 1'b1);
    chk("full_out_data", bus.out_data, 32'h10);
    chk("full_occ", occupancy_o, 3'd4);
    chk("bp_in_ready", bus.in_ready, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_s3", sdata(3), 32'h10);
      chk("bp_s0", sdata(0), 32'h13);
      chk("bp_occ", occupancy_o, 3'd4);
    end

    // release: order preserved, one item per cycle
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      #1;
      chk("rel_valid", bus.out_valid, 1'b1);
      chk("rel_data", bus.out_data, 32'h10 + i);
      tick();
    end
    chk("drain_valid", bus.out_valid, 1'b0);
    chk("drain_occ", occupancy_o, 3'd0);

    // mid-stall on stage 1
    fill(32'h30);
    bus.out_ready = 1'b1;
    stall_i       = 4'b0010;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h34;
    #1;
    chk("mid_in_ready", bus.in_ready, 1'b0);
    chk("mid_out_data0", bus.out_data, 32'h30);
    tick();
    chk("mid_valid1", stage_valid_o, 4'b1011);
    chk("mid_out_data1", bus.out_data, 32'h31);
    tick();
    chk("mid_valid2", stage_valid_o, 4'b0011);
    stall_i      = '0;
    bus.in_valid = 1'b0;
    tick();
    chk("mid_rel_valid", stage_valid_o, 4'b0110);
    chk("mid_rel_s2", sdata(2), 32'h32);
    chk("mid_rel_s1", sdata(1), 32'h33);
    tick();
    chk("mid_out_32", bus.out_data, 32'h32);
    tick();
    chk("mid_out_33", bus.out_data, 32'h33);
    tick();
    chk("mid_empty", occupancy_o, 3'd0);

    // flush of the two youngest stages
    fill(32'h40);
    chk("fl_occ", occupancy_o, 3'd4);
    chk("fl_drop0", drop_cnt_o, 16'd0);
    flush_i       = 4'b0011;
    bus.out_ready = 1'b1;
    tick();
    flush_i = '0;
    chk("fl_valid", stage_valid_o, 4'b1100);
    chk("fl_drop", drop_cnt_o, 16'd2);
    chk("fl_s2_adv", sdata(2), 32'h42);
    chk("fl_out", bus.out_data, 32'h41);

    // flush together with stall on the oldest stage
    stall_i = 4'b1000;
    flush_i = 4'b1000;
    #1;
    chk("fh_out_valid", bus.out_valid, 1'b0);
    tick();
    stall_i = '0;
    flush_i = '0;
    chk("fh_valid", stage_valid_o, 4'b0100);
    chk("fh_drop", drop_cnt_o, 16'd3);
    chk("fh_s2_kept", sdata(2), 32'h42);

    // asynchronous reset mid-stream
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h50;
    tick();
    bus.in_valid = 1'b0;
    chk("rs_pre_valid", stage_valid_o, 4'b1001);
    #2 reset = 1'b0;
    #1;
    chk("rs_out_valid", bus.out_valid, 1'b0);
    chk("rs_occ", occupancy_o, 3'd0);
    chk("rs_drop", drop_cnt_o, 16'd0);
    chk("rs_stage_valid", stage_valid_o, 4'b0000);
    #1 reset = 1'b1;
    tick();
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h60;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int e = 1; e < N; e++) begin
      chk("rs_lat_not_yet", bus.out_valid, 1'b0);
      tick();
    end
    chk("rs_lat_valid", bus.out_valid, 1'b1);
    chk("rs_lat_data", bus.out_data, 32'h60);
    tick();

    // stall behind an empty youngest stage
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h70 + i;
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    chk("ce_pre_valid", stage_valid_o, 4'b1110);
    stall_i      = 4'b0010;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h20;
    #1;
    chk("ce_in_ready", bus.in_ready, COLLAPSE ? 1'b1 : 1'b0);
    tick();
    stall_i      = '0;
    bus.in_valid = 1'b0;
    chk("ce_valid", stage_valid_o, COLLAPSE ? 4'b1111 : 4'b1110);
    if (COLLAPSE) begin
      chk("ce_s0_data", sdata(0), 32'h20);
    end
    chk("ce_s3_kept", sdata(3), 32'h70);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
